nfca_rx_window_ctrl: RTL and testbench
======================================

// Module: nfca_rx_window_ctrl
// PURPOSE
//  Sequences the PICC-to-PCD receive window. After the TX path finishes a PCD frame, it holds rx_on low for a guard
//  time, then opens rx_on for nfca_rx_tobits and supervises the response: first-bit timeout, inter-bit watchdog and
//  frame-length limit. It closes the window and reports one completion status with the received bit count.
//  It sits between the top-level NFC-A controller FSM and nfca_rx_dsp/nfca_rx_tobits. Nominal clk is 81.36 MHz (6*fc).
// PARAMETERS
//  GUARD_CYC    6000    clk cycles rx_on is held low after start (suppresses PCD echo, < FDT 1172/fc)
//  TIMEOUT_CYC  406800  clk cycles in LISTEN with no bit before timeout (~5 ms)
//  WDOG_CYC     2304    max clk cycles between tobits events in RECV (3 bit periods of 768 clk)
//  MAX_BITS     4096    max data bits accepted per frame; BCW = $clog2(MAX_BITS+1)
// PORTS
//  clk          in   1    clock
//  rstn         in   1    reset, asynchronous, active-low
//  start        in   1    pulse: PCD TX frame finished, arm receive window
//  abort        in   1    pulse: cancel window immediately
//  rx_bit_en    in   1    from tobits: rx_bit valid
//  rx_end       in   1    from tobits: end-of-frame pulse
//  rx_end_col   in   1    from tobits: collision, valid with rx_end
//  rx_end_err   in   1    from tobits: error, valid with rx_end
//  rx_on        out  1    enable to nfca_rx_dsp / nfca_rx_tobits
//  busy         out  1    1 in every state except IDLE
//  done         out  1    one-cycle completion pulse
//  status       out  3    completion code, valid with done and held until next done
//  bit_count    out  BCW  data bits received; counts during RECV, held after done
// BEHAVIOUR
//  Reset: rx_on=0, busy=0, done=0, status=ST_OK, bit_count=0, state=IDLE, counters=0. All outputs are registered.
//  IDLE: start -> GUARD, bit_count<=0, cnt<=0. abort in IDLE is ignored. start when not IDLE is ignored.
//  GUARD: rx_on=0; tobits inputs ignored; cnt counts. When cnt==GUARD_CYC-1 -> LISTEN, cnt<=0. rx_on=1 from the next cycle.
//  LISTEN: rx_on=1; first rx_bit_en -> RECV, bit_count<=1, cnt<=0.
//    rx_end (no bits yet) -> DONE with ST_ERR (empty frame); cnt==TIMEOUT_CYC-1 -> DONE with ST_TIMEOUT.
//  RECV: each rx_bit_en: bit_count++ and cnt<=0.
//    rx_bit_en with bit_count==MAX_BITS -> DONE ST_OVF (bit not counted).
//    rx_end: rx_end_err -> ST_ERR; else rx_end_col -> ST_COL (bit_count = collision position); else ST_OK.
//    cnt==WDOG_CYC-1 with no event -> DONE with ST_WDOG.
//  DONE (1 cycle): rx_on=0, done=1, status updated, busy=1; -> IDLE. Completion to done/rx_on low takes 1 cycle.
//  abort in GUARD/LISTEN/RECV -> DONE with ST_ABORT. abort has priority over every same-cycle event.
//  Same-cycle rx_end and rx_bit_en: rx_end wins, bit not counted. rx_end_err has priority over rx_end_col.
//  Counter widths: cnt is $clog2(max of the *_CYC) bits. No wrap is possible, since every state exits before terminal count.
//  Async reset mid-window: rx_on drops immediately, and no done pulse is produced.
// STRUCTURE
//  Package nfca_pkg: state enum (IDLE,GUARD,LISTEN,RECV,DONE) and status localparams
//    ST_OK=0, ST_COL=1, ST_ERR=2, ST_TIMEOUT=3, ST_OVF=4, ST_ABORT=5, ST_WDOG=6.
//  Single FSM + one shared down/up counter. No sub-module needed. Optional shared nfca_cyc_timer for cnt/terminal-count reuse.
// TESTING
//  1 start; after GUARD_CYC, 9 rx_bit_en 768 clk apart, then rx_end
//    -> rx_on rises 6000 clk after start; done, status=0, bit_count=9.
//  2 start, no tobits activity -> done at start+6000+406800+1 (±1 clk); status=3, bit_count=0; rx_on low after.
//  3 start, 5 bits, then rx_end+rx_end_col -> status=1, bit_count=5; same-cycle rx_end_err added -> status=2.
//  4 MAX_BITS=8: start, 9 bits -> done on 9th bit, status=4, bit_count=8.
//  5 start, 3 bits, abort together with rx_bit_en -> status=5, bit_count=3. Then a 2nd start during DONE is ignored.
//  6 rx_bit_en pulses during GUARD are ignored (bit_count=0). In RECV, a 2400-clk gap -> status=6.
//    Reset asserted in LISTEN -> all outputs 0 next edge.

Source files
------------

// File: rtl/nfca_pkg.sv
// Shared types for the NFC-A receive-window controller.
// Defines the FSM state encoding and the completion status codes.
package nfca_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GUARD  = 3'd1,
    LISTEN = 3'd2,
    RECV   = 3'd3,
    DONE   = 3'd4
  } win_state_t;

  localparam logic [2:0] ST_OK      = 3'd0;
  localparam logic [2:0] ST_COL     = 3'd1;
  localparam logic [2:0] ST_ERR     = 3'd2;
  localparam logic [2:0] ST_TIMEOUT = 3'd3;
  localparam logic [2:0] ST_OVF     = 3'd4;
  localparam logic [2:0] ST_ABORT   = 3'd5;
  localparam logic [2:0] ST_WDOG    = 3'd6;

endpackage

// File: rtl/nfca_rx_window_ctrl.sv
// PICC-to-PCD receive window sequencer: guard time, listen with first-bit timeout,
// receive with inter-bit watchdog and frame-length limit, then one completion status.
module nfca_rx_window_ctrl
  import nfca_pkg::*;
#(
  parameter int GUARD_CYC   = 6000,
  parameter int TIMEOUT_CYC = 406800,
  parameter int WDOG_CYC    = 2304,
  parameter int MAX_BITS    = 4096,
  localparam int BCW        = $clog2(MAX_BITS + 1)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           start,
  input  logic           abort,
  input  logic           rx_bit_en,
  input  logic           rx_end,
  input  logic           rx_end_col,
  input  logic           rx_end_err,
  output logic           rx_on,
  output logic           busy,
  output logic           done,
  output logic [2:0]     status,
  output logic [BCW-1:0] bit_count
);

  localparam int MAX_GW  = (GUARD_CYC > WDOG_CYC) ? GUARD_CYC : WDOG_CYC;
  localparam int CNT_MAX = (MAX_GW > TIMEOUT_CYC) ? MAX_GW : TIMEOUT_CYC;
  localparam int CW      = $clog2(CNT_MAX);

  win_state_t     state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [BCW-1:0] bc_n;
  logic [2:0]     st_n;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_count <= '0;
      status    <= ST_OK;
      rx_on     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_count <= bc_n;
      status    <= st_n;
      // Outputs are registered from the next state so they line up with it.
      rx_on     <= (state_n == LISTEN) || (state_n == RECV);
      busy      <= (state_n != IDLE);
      done      <= (state_n == DONE);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bc_n    = bit_count;
    st_n    = status;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = GUARD;
          cnt_n   = '0;
          bc_n    = '0;
        end
      end
      GUARD: begin
        if (abort) begin
          state_n = DONE;
          st_n    = ST_ABORT;
          cnt_n   = '0;
        end else if (cnt == CW'(GUARD_CYC - 1)) begin
          state_n = LISTEN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      LISTEN: begin
        if (abort) begin
          state_n = DONE;
          st_n    = ST_ABORT;
          cnt_n   = '0;
        end else if (rx_end) begin
          state_n = DONE;
          st_n    = ST_ERR;
          cnt_n   = '0;
        end else if (rx_bit_en) begin
          state_n = RECV;
          bc_n    = BCW'(1);
          cnt_n   = '0;
        end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
          state_n = DONE;
          st_n    = ST_TIMEOUT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RECV: begin
        // abort beats rx_end, which beats a same-cycle bit.
        if (abort) begin
          state_n = DONE;
          st_n    = ST_ABORT;
          cnt_n   = '0;
        end else if (rx_end) begin
          state_n = DONE;
          st_n    = rx_end_err ? ST_ERR : (rx_end_col ? ST_COL : ST_OK);
          cnt_n   = '0;
        end else if (rx_bit_en) begin
          cnt_n = '0;
          if (bit_count == BCW'(MAX_BITS)) begin
            state_n = DONE;
            st_n    = ST_OVF;
          end else begin
            bc_n = bit_count + BCW'(1);
          end
        end else if (cnt == CW'(WDOG_CYC - 1)) begin
          state_n = DONE;
          st_n    = ST_WDOG;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_nfca_rx_window_ctrl.sv
// Directed bench for nfca_rx_window_ctrl with scaled-down timing parameters.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_nfca_rx_window_ctrl;
  import nfca_pkg::*;

  localparam int GUARD_CYC   = 60;
  localparam int TIMEOUT_CYC = 1000;
  localparam int WDOG_CYC    = 24;
  localparam int MAX_BITS    = 16;
  localparam int BCW         = $clog2(MAX_BITS + 1);
  localparam int BIT_GAP     = 8;

  logic           clk = 1'b0;
  logic           rstn;
  logic           start, abort, rx_bit_en, rx_end, rx_end_col, rx_end_err;
  logic           rx_on, busy, done;
  logic [2:0]     status;
  logic [BCW-1:0] bit_count;

  int n_tests = 0;
  int n_fail  = 0;
  int n;

  nfca_rx_window_ctrl #(
    .GUARD_CYC  (GUARD_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .WDOG_CYC   (WDOG_CYC),
    .MAX_BITS   (MAX_BITS)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .abort     (abort),
    .rx_bit_en (rx_bit_en),
    .rx_end    (rx_end),
    .rx_end_col(rx_end_col),
    .rx_end_err(rx_end_err),
    .rx_on     (rx_on),
    .busy      (busy),
    .done      (done),
    .status    (status),
    .bit_count (bit_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic bit_pulse();
    rx_bit_en = 1'b1;
    tick();
    rx_bit_en = 1'b0;
  endtask

  task automatic send_bits(input int count);
    for (int i = 0; i < count; i++) begin
      bit_pulse();
      repeat (BIT_GAP - 1) tick();
    end
  endtask

  task automatic wait_done(input int limit, output int cycles);
    cycles = 0;
    while (!done && cycles < limit) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0;
    rx_bit_en = 1'b0; rx_end = 1'b0; rx_end_col = 1'b0; rx_end_err = 1'b0;
    repeat (3) tick();
    check("rst_rx_on", rx_on, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_status", status, ST_OK);
    check("rst_bit_count", bit_count, 0);
    rstn = 1'b1;
    tick();

    // abort while idle does nothing
    abort = 1'b1; tick(); abort = 1'b0;
    check("idle_abort_busy", busy, 0);
    check("idle_abort_done", done, 0);

    // 1: normal 9-bit frame
    do_start();
    check("t1_busy", busy, 1);
    check("t1_guard_rx_on", rx_on, 0);
    n = 0;
    while (!rx_on && n < GUARD_CYC + 20) begin tick(); n++; end
    check("t1_guard_len", n, GUARD_CYC);
    send_bits(9);
    rx_end = 1'b1; tick(); rx_end = 1'b0;
    check("t1_done", done, 1);
    check("t1_status", status, ST_OK);
    check("t1_bit_count", bit_count, 9);
    check("t1_rx_on_off", rx_on, 0);
    check("t1_busy_done", busy, 1);
    tick();
    check("t1_done_clr", done, 0);
    check("t1_busy_clr", busy, 0);
    check("t1_status_hold", status, ST_OK);
    check("t1_bc_hold", bit_count, 9);

    // 2: no response -> timeout
    do_start();
    wait_done(GUARD_CYC + TIMEOUT_CYC + 20, n);
    check("t2_done_time", n, GUARD_CYC + TIMEOUT_CYC);
    check("t2_status", status, ST_TIMEOUT);
    check("t2_bit_count", bit_count, 0);
    check("t2_rx_on", rx_on, 0);
    tick();

    // 3a: collision after 5 bits
    do_start();
    repeat (GUARD_CYC) tick();
    check("t3_listen_rx_on", rx_on, 1);
    send_bits(5);
    rx_end = 1'b1; rx_end_col = 1'b1; tick();
    rx_end = 1'b0; rx_end_col = 1'b0;
    check("t3_col_done", done, 1);
    check("t3_col_status", status, ST_COL);
    check("t3_col_bc", bit_count, 5);
    tick();

    // 3b: error has priority over collision; same-cycle bit not counted
    do_start();
    repeat (GUARD_CYC) tick();
    send_bits(5);
    rx_end = 1'b1; rx_end_col = 1'b1; rx_end_err = 1'b1; rx_bit_en = 1'b1; tick();
    rx_end = 1'b0; rx_end_col = 1'b0; rx_end_err = 1'b0; rx_bit_en = 1'b0;
    check("t3_err_done", done, 1);
    check("t3_err_status", status, ST_ERR);
    check("t3_err_bc", bit_count, 5);
    tick();

    // 4: overflow on bit MAX_BITS+1
    do_start();
    repeat (GUARD_CYC) tick();
    send_bits(MAX_BITS);
    check("t4_pre_ovf_done", done, 0);
    check("t4_pre_ovf_bc", bit_count, MAX_BITS);
    bit_pulse();
    check("t4_ovf_done", done, 1);
    check("t4_ovf_status", status, ST_OVF);
    check("t4_ovf_bc", bit_count, MAX_BITS);

    // 5: abort beats a same-cycle bit; start during DONE is ignored
    tick();
    do_start();
    repeat (GUARD_CYC) tick();
    send_bits(3);
    abort = 1'b1; rx_bit_en = 1'b1; tick();
    abort = 1'b0; rx_bit_en = 1'b0;
    check("t5_abort_done", done, 1);
    check("t5_abort_status", status, ST_ABORT);
    check("t5_abort_bc", bit_count, 3);
    do_start();
    check("t5_restart_busy", busy, 0);
    tick();
    check("t5_restart_busy2", busy, 0);
    check("t5_restart_rx_on", rx_on, 0);

    // 6: bits during guard ignored; watchdog on long gap
    do_start();
    for (int i = 0; i < 10; i++) begin
      bit_pulse();
      repeat (4) tick();
    end
    repeat (GUARD_CYC - 50) tick();
    check("t6_guard_end_rx_on", rx_on, 1);
    check("t6_guard_bc", bit_count, 0);
    bit_pulse();
    repeat (BIT_GAP - 1) tick();
    bit_pulse();
    wait_done(WDOG_CYC + 20, n);
    check("t6_wdog_time", n, WDOG_CYC);
    check("t6_wdog_status", status, ST_WDOG);
    check("t6_wdog_bc", bit_count, 2);
    tick();

    // async reset while listening
    do_start();
    repeat (GUARD_CYC) tick();
    check("t6_rst_pre_rx_on", rx_on, 1);
    #2 rstn = 1'b0;
    #1;
    check("t6_rst_async_rx_on", rx_on, 0);
    check("t6_rst_async_busy", busy, 0);
    tick();
    check("t6_rst_done", done, 0);
    check("t6_rst_status", status, ST_OK);
    check("t6_rst_bc", bit_count, 0);
    rstn = 1'b1;
    repeat (3) tick();
    check("t6_post_rst_done", done, 0);
    check("t6_post_rst_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
